fetch_sequencer: RTL

//  Instruction-fetch controller for the pipelined LEGv8 core; owns the PC and drives the 128-word imem.
//  - imem is a combinational-read ROM: addr[6:0] -> q[31:0].
//  - Registers the fetched word into the IF/ID stage.
//  - Applies decode-stage stall and execute-stage branch redirect.
//  - Detects end of program (halt) and PC range faults.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/pc_range_chk.sv | 14 +
 rtl/fetch_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and range check for the instruction fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h8b1f03ff;
    localparam logic [31:0] HALT_INSTR = 32'hb400001f;
    localparam int          IMEM_WORDS = 128;

    // Word aligned and inside the imem window of 2**aw words.
    function automatic logic in_range(input logic [63:0] pc, input int aw);
        return (pc[1:0] == 2'b00) && ((pc >> (aw + 2)) == 64'd0);
    endfunction

endpackage

// File: rtl/pc_range_chk.sv
// rtl/pc_range_chk.sv - combinational alignment and imem-window check for a byte PC
module pc_range_chk
    import fetch_pkg::*;
#(
    parameter int PCW = 64,
    parameter int AW  = 7
) (
    input  logic [PCW-1:0] addr,
    output logic           ok
);

    assign ok = in_range(64'(addr), AW);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - LEGv8 fetch controller: owns the PC, drives imem, fills IF/ID
// Handles stall, branch redirect, halt on CBZ XZR,#0 and sticky PC range faults.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int N   = 32,
    parameter int AW  = 7,
    parameter int PCW = 64
) (
    input  logic           clk,
    input  logic           reset,
    output logic [AW-1:0]  imem_addr,
    input  logic [N-1:0]   imem_q,
    input  logic           stall,
    input  logic           branch_taken,
    input  logic [PCW-1:0] branch_target,
    output logic [PCW-1:0] if_pc,
    output logic [N-1:0]   if_instr,
    output logic           if_valid,
    output logic           halted,
    output logic           fault,
    output logic [31:0]    fetch_count
);

    fetch_state_t   state, state_n;
    logic [PCW-1:0] pc, pc_n, pc_next4, if_pc_n;
    logic [N-1:0]   if_instr_n;
    logic           if_valid_n, halted_n, fault_n;
    logic [31:0]    count_n;
    logic           target_ok, next4_ok;

    assign pc_next4  = pc + PCW'(4);
    assign imem_addr = pc[AW+1:2];

    pc_range_chk #(.PCW(PCW), .AW(AW)) u_target_chk (
        .addr (branch_target),
        .ok   (target_ok)
    );

    pc_range_chk #(.PCW(PCW), .AW(AW)) u_next4_chk (
        .addr (pc_next4),
        .ok   (next4_ok)
    );

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        if_pc_n    = if_pc;
        if_instr_n = if_instr;
        if_valid_n = if_valid;
        halted_n   = halted;
        fault_n    = fault;
        count_n    = fetch_count;

        if (state == FAULT) begin
            if_valid_n = 1'b0;
            if_instr_n = N'(NOP_INSTR);
        end else if (branch_taken) begin
            // A redirect squashes whatever is in IF/ID but leaves if_pc alone.
            if_valid_n = 1'b0;
            if_instr_n = N'(NOP_INSTR);
            if (target_ok) begin
                pc_n     = branch_target;
                state_n  = RUN;
                halted_n = 1'b0;
            end else begin
                state_n = FAULT;
                fault_n = 1'b1;
            end
        end else if (stall) begin
            state_n = state;
        end else if (state == RUN) begin
            if_instr_n = imem_q;
            if_pc_n    = pc;
            if_valid_n = 1'b1;
            count_n    = fetch_count + 32'd1;
            pc_n       = pc_next4;
            if (imem_q == N'(HALT_INSTR)) begin
                state_n  = HALT;
                halted_n = 1'b1;
            end else if (!next4_ok) begin
                state_n = FAULT;
                fault_n = 1'b1;
            end
        end else begin
            if_valid_n = 1'b0;
            if_instr_n = N'(NOP_INSTR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            pc          <= '0;
            if_pc       <= '0;
            if_instr    <= N'(NOP_INSTR);
            if_valid    <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            if_pc       <= if_pc_n;
            if_instr    <= if_instr_n;
            if_valid    <= if_valid_n;
            halted      <= halted_n;
            fault       <= fault_n;
            fetch_count <= count_n;
        end
    end

endmodule
